// File: rtl/ahb_lite_resp_pkg.sv
// Shared encodings, FSM state type and sizing helper for the AHB-Lite responder bridge.
package ahb_lite_resp_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_e;

  // Largest legal hsize for a data bus of dw bits.
  function automatic int unsigned max_hsize(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/ahb_lite_resp_strb_gen.sv
// Combinational byte-strobe and alignment decode for one transfer.
module ahb_lite_resp_strb_gen #(
  parameter int unsigned DW = 32,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned LB = $clog2(NB)
) (
  input  logic [2:0]    hsize_i,
  input  logic [LB-1:0] addr_lo_i,
  output logic [NB-1:0] wstrb_o,
  output logic          misaligned_o
);

  logic [NB-1:0] ones;
  logic [31:0]   align_mask;

  always_comb begin
    // 2**hsize contiguous ones; oversize values are rejected by the caller.
    ones         = NB'((64'd1 << (32'd1 << hsize_i)) - 64'd1);
    wstrb_o      = ones << addr_lo_i;
    align_mask   = (32'd1 << hsize_i) - 32'd1;
    misaligned_o = |(addr_lo_i & align_mask[LB-1:0]);
  end

endmodule

// File: rtl/ahb_lite_resp_bridge.sv
// AHB-Lite responder to req/ack backend bridge: wait states, size/alignment
// checks, two-cycle ERROR response and optional backend timeout.
module ahb_lite_resp_bridge
  import ahb_lite_resp_pkg::*;
#(
  parameter int unsigned AHB_LITE_ADDR_WIDTH = 32,
  parameter int unsigned AHB_LITE_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES      = 0
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [AHB_LITE_ADDR_WIDTH-1:0]   haddr_i,
  input  logic [AHB_LITE_DATA_WIDTH-1:0]   hwdata_i,
  input  logic                             hsel_i,
  input  logic                             hwrite_i,
  input  logic                             hready_i,
  input  logic [1:0]                       htrans_i,
  input  logic [2:0]                       hsize_i,
  output logic                             hresp_o,
  output logic                             hreadyout_o,
  output logic [AHB_LITE_DATA_WIDTH-1:0]   hrdata_o,
  output logic                             req_o,
  output logic                             we_o,
  output logic [AHB_LITE_ADDR_WIDTH-1:0]   addr_o,
  output logic [AHB_LITE_DATA_WIDTH-1:0]   wdata_o,
  output logic [AHB_LITE_DATA_WIDTH/8-1:0] wstrb_o,
  input  logic                             ack_i,
  input  logic [AHB_LITE_DATA_WIDTH-1:0]   rdata_i,
  input  logic                             err_i
);

  localparam int unsigned AW        = AHB_LITE_ADDR_WIDTH;
  localparam int unsigned DW        = AHB_LITE_DATA_WIDTH;
  localparam int unsigned NB        = DW / 8;
  localparam int unsigned LB        = $clog2(NB);
  localparam int unsigned MAX_HSIZE = max_hsize(DW);
  localparam int unsigned CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [NB-1:0] strb_q, strb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NB-1:0] strb;
  logic          misaligned;
  logic          accept;
  logic          illegal;
  logic          take;
  logic          timeout_hit;

  ahb_lite_resp_strb_gen #(
    .DW (DW)
  ) u_strb_gen (
    .hsize_i      (hsize_i),
    .addr_lo_i    (haddr_i[LB-1:0]),
    .wstrb_o      (strb),
    .misaligned_o (misaligned)
  );

  assign accept      = hsel_i & hready_i & (htrans_i inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign illegal     = (32'(hsize_i) > MAX_HSIZE) | misaligned;
  // Fires on the last allowed wait cycle so req_o is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  assign addr_o  = addr_q;
  assign wstrb_o = strb_q;
  assign wdata_o = hwdata_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    strb_d      = strb_q;
    cnt_d       = cnt_q;
    take        = 1'b0;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    req_o       = 1'b0;
    we_o        = 1'b0;
    hrdata_o    = '0;

    unique case (state_q)
      IDLE: take = 1'b1;
      ACCESS: begin
        req_o       = 1'b1;
        we_o        = we_q;
        hreadyout_o = ack_i & ~err_i;
        if (ack_i) begin
          if (err_i) begin
            state_d = ERR1;
          end else begin
            take    = 1'b1;
            state_d = IDLE;
            if (!we_q) hrdata_o = rdata_i;
          end
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (timeout_hit) state_d = ERR1;
        end
      end
      ERR1: begin
        hresp_o     = HRESP_ERROR;
        hreadyout_o = 1'b0;
        state_d     = ERR2;
      end
      ERR2: begin
        hresp_o = HRESP_ERROR;
        take    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new address phase is only taken in cycles where this responder is ready.
    if (take && accept) begin
      addr_d  = haddr_i;
      we_d    = hwrite_i;
      strb_d  = strb;
      cnt_d   = '0;
      state_d = illegal ? ERR1 : ACCESS;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
